multicycle_controller: RTL

Multi-cycle sequencing FSM for the RV32I core variant that shares one instruction fetch port and one data memory port across several clocks per instruction. It consumes the combinational control outputs of the main decoder and emits per-state enables (instruction-register load, data-memory request, memory-data load, register-file write, PC update). It handles ready/request handshakes with instruction and data memory, with an optional wait-timeout fault.

---
 rtl/multicycle_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: shares one fetch port and one data port across FETCH/DECODE/EXEC/MEM/WB.
// Latency: ALU/branch/jump 4 cycles, load 5, store 4, plus one cycle per memory wait cycle.
// Backpressure: imem_req/dmem_req stay high until the matching ready is sampled; never withdrawn.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset (all outputs forced to 0 while high)
//   imem_req / imem_ready    instruction fetch handshake; ir_load pulses when the fetch completes
//   dec_*                    decoder control outputs, read only in EXEC, MEM and WB
//   dmem_req / dmem_we       data access request and write strobe; dmem_ready completes it
//   mdr_load                 latch load data on load completion
//   rf_we, pc_write          register-file write and PC update enables
//   instr_retired            one-cycle pulse per completed instruction
//   state                    current state encoding
//   fault                    sticky wait-timeout fault
//
// Optional feature: define MCYC_TIMEOUT_EN to bound memory waits to TIMEOUT_CYCLES, after
// which the FSM parks in FAULT until reset. Without it waits are unbounded and fault is 0.

module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       ir_load,
    input  logic       dec_reg_write,
    input  logic       dec_mem_read,
    input  logic       dec_mem_write,
    input  logic       dec_branch,
    input  logic       dec_jump,
    input  logic       dec_jalr,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       mdr_load,
    output logic       rf_we,
    output logic       pc_write,
    output logic       instr_retired,
    output logic [2:0] state,
    output logic       fault
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    logic [2:0] state_q;
    logic [2:0] state_d;

    // Branch/jump target selection lives in the datapath; these all take the WB path here.
    logic unused_dec;
    assign unused_dec = dec_branch ^ dec_jump ^ dec_jalr;

    // Both read and write high is treated as a store.
    logic is_store;
    logic is_load;
    assign is_store = dec_mem_write;
    assign is_load  = dec_mem_read & ~dec_mem_write;

    // True in a cycle spent waiting on a memory ready.
    logic waiting;
    assign waiting = ((state_q == ST_FETCH) & ~imem_ready) |
                     ((state_q == ST_MEM)   & ~dmem_ready);

`ifdef MCYC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Current wait cycle is the TIMEOUT_CYCLES-th one without ready; a ready in it wins
    // because waiting is already low then.
    assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
            wait_cnt <= '0;
        end else if (waiting && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready)       state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_FAULT;
                else                  state_d = ST_FETCH;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_mem_read | dec_mem_write) state_d = ST_MEM;
                else                              state_d = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready)       state_d = is_store ? ST_FETCH : ST_WB;
                else if (timeout_hit) state_d = ST_FAULT;
                else                  state_d = ST_MEM;
            end
            ST_WB: state_d = ST_FETCH;
`ifdef MCYC_TIMEOUT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            // 6/7 (and FAULT when the timeout is compiled out) recover to FETCH.
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Every output is gated by ~rst so an instruction caught by reset never writes or retires.
    logic run;
    logic mem_done;
    assign run      = ~rst;
    assign mem_done = run && (state_q == ST_MEM) && dmem_ready;

    always_comb begin
        imem_req      = run && (state_q == ST_FETCH);
        ir_load       = run && (state_q == ST_FETCH) && imem_ready;
        dmem_req      = run && (state_q == ST_MEM);
        dmem_we       = run && (state_q == ST_MEM) && is_store;
        mdr_load      = mem_done && is_load;
        rf_we         = run && (state_q == ST_WB) && dec_reg_write;
        pc_write      = (run && (state_q == ST_WB)) || (mem_done && is_store);
        instr_retired = (run && (state_q == ST_WB)) || (mem_done && is_store);
        state         = run ? state_q : 3'd0;
`ifdef MCYC_TIMEOUT_EN
        fault         = run && (state_q == ST_FAULT);
`else
        fault         = 1'b0;
`endif
    end

endmodule
